// File: rtl/picosoc_bus_decoder_if.sv
// Native PicoRV32 memory bus as seen by the address decoder: the CPU request
// port on one side and the shared request / per-slave response lines on the other.
interface picosoc_bus_decoder_if #(
    parameter int NUM_SLAVES = 4
);
    // Handshake on both sides: the requester raises valid with addr/wstrb/wdata
    // stable and holds it until the responder's ready is sampled high; ready is
    // a single-cycle pulse and rdata is meaningful only in that cycle. wstrb==0
    // marks a read.
    logic                    mem_valid;
    logic [31:0]             mem_addr;
    logic [3:0]              mem_wstrb;
    logic [31:0]             mem_wdata;
    logic                    mem_ready;
    logic [31:0]             mem_rdata;

    logic [NUM_SLAVES-1:0]   s_valid;
    logic [31:0]             s_addr;
    logic [3:0]              s_wstrb;
    logic [31:0]             s_wdata;
    logic [NUM_SLAVES-1:0]   s_ready;
    logic [32*NUM_SLAVES-1:0] s_rdata;

    // The environment: CPU driving requests and slaves driving responses.
    modport master (
        output mem_valid, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rdata,
        input  s_valid, s_addr, s_wstrb, s_wdata,
        output s_ready, s_rdata
    );

    // The decoder itself.
    modport slave (
        input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rdata,
        output s_valid, s_addr, s_wstrb, s_wdata,
        input  s_ready, s_rdata
    );
endinterface

// File: rtl/picosoc_bus_decoder.sv
// Base/mask address decoder between the PicoRV32 memory port and NUM_SLAVES
// slaves, with registered select/response, unmapped/timeout error capture.
module picosoc_bus_decoder #(
    parameter int                       NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE     = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK     = {NUM_SLAVES{32'h0}},
    parameter int                       TIMEOUT_CYCLES = 255,
    parameter logic [31:0]              ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  reset,
    picosoc_bus_decoder_if.slave  bus,
    input  logic                  err_clear,
    output logic                  err_flag,
    output logic [31:0]           err_addr,
    output logic [1:0]            state_dbg   // 0 = IDLE, 1 = WAIT, 2 = RESP
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TMR_W-1:0] TIMER_LAST =
        (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [NUM_SLAVES-1:0] s_valid_q, s_valid_d;
    logic                  mem_ready_q, mem_ready_d;
    logic [31:0]           mem_rdata_q, mem_rdata_d;
    logic [31:0]           s_addr_q, s_addr_d;
    logic [3:0]            s_wstrb_q, s_wstrb_d;
    logic [31:0]           s_wdata_q, s_wdata_d;
    logic                  err_flag_q, err_flag_d;
    logic [31:0]           err_addr_q, err_addr_d;

    logic                  hit_any;
    logic [SEL_W-1:0]      hit_idx;
    logic                  sel_ready;
    logic [31:0]           sel_rdata;

    // Walk from the top index down so the lowest-index hit is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus.mem_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit_any = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    assign sel_ready = bus.s_ready[sel_q];
    assign sel_rdata = bus.s_rdata[32*sel_q +: 32];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            timer_q     <= '0;
            s_valid_q   <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            s_addr_q    <= '0;
            s_wstrb_q   <= '0;
            s_wdata_q   <= '0;
            err_flag_q  <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            timer_q     <= timer_d;
            s_valid_q   <= s_valid_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            s_addr_q    <= s_addr_d;
            s_wstrb_q   <= s_wstrb_d;
            s_wdata_q   <= s_wdata_d;
            err_flag_q  <= err_flag_d;
            err_addr_q  <= err_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        timer_d     = '0;
        s_valid_d   = '0;
        mem_ready_d = 1'b0;
        mem_rdata_d = mem_rdata_q;
        s_addr_d    = s_addr_q;
        s_wstrb_d   = s_wstrb_q;
        s_wdata_d   = s_wdata_q;
        // A clear is applied first so an error raised below in the same cycle overrides it.
        err_flag_d  = err_clear ? 1'b0 : err_flag_q;
        err_addr_d  = err_addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.mem_valid) begin
                    s_addr_d  = bus.mem_addr;
                    s_wstrb_d = bus.mem_wstrb;
                    s_wdata_d = bus.mem_wdata;
                    if (hit_any) begin
                        sel_d              = hit_idx;
                        s_valid_d[hit_idx] = 1'b1;
                        state_d            = ST_WAIT;
                    end else begin
                        mem_rdata_d = ERR_RDATA;
                        mem_ready_d = 1'b1;
                        err_flag_d  = 1'b1;
                        err_addr_d  = bus.mem_addr;
                        state_d     = ST_RESP;
                    end
                end
            end

            ST_WAIT: begin
                if (!bus.mem_valid) begin
                    // CPU withdrew its request: drop silently, nothing to report.
                    state_d = ST_IDLE;
                end else if (sel_ready) begin
                    mem_rdata_d = sel_rdata;
                    mem_ready_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (TIMEOUT_EN && (timer_q == TIMER_LAST)) begin
                    mem_rdata_d = ERR_RDATA;
                    mem_ready_d = 1'b1;
                    err_flag_d  = 1'b1;
                    err_addr_d  = s_addr_q;
                    state_d     = ST_RESP;
                end else begin
                    timer_d   = timer_q + 1'b1;
                    s_valid_d = s_valid_q;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.s_valid   = s_valid_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.s_wstrb   = s_wstrb_q;
    assign bus.s_wdata   = s_wdata_q;
    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign err_flag      = err_flag_q;
    assign err_addr      = err_addr_q;
    assign state_dbg     = state_q;

    // Structural invariants of the registered outputs.
    a_sel_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(bus.s_valid));
    a_ready_pulse : assert property (@(posedge clk) disable iff (reset)
        bus.mem_ready |=> !bus.mem_ready);
    a_ready_excl : assert property (@(posedge clk) disable iff (reset)
        !(bus.mem_ready && (|bus.s_valid)));

endmodule

// File: tb/tb_picosoc_bus_decoder.sv
// Randomized bench for picosoc_bus_decoder, checked against a transaction-level
// model of the decode map, response latency and error flag.
module tb_picosoc_bus_decoder;

    localparam int          NS  = 4;
    localparam int          TMO = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
    localparam logic [32*NS-1:0] BASE_P =
        {32'h1000_0000, 32'h0400_0000, 32'h0200_0000, 32'h0000_0000};
    localparam logic [32*NS-1:0] MASK_P =
        {32'hFFFF_FFF0, 32'hFF00_0000, 32'hFFFF_F000, 32'hFDFF_FC00};

    // Reference decode map, slave 0 first.
    logic [31:0] base_tab [NS] = '{32'h0000_0000, 32'h0200_0000, 32'h0400_0000, 32'h1000_0000};
    logic [31:0] mask_tab [NS] = '{32'hFDFF_FC00, 32'hFFFF_F000, 32'hFF00_0000, 32'hFFFF_FFF0};

    logic        clk;
    logic        reset;
    logic        err_clear;
    logic        err_flag;
    logic [31:0] err_addr;
    logic [1:0]  state_dbg;

    picosoc_bus_decoder_if #(.NUM_SLAVES(NS)) bus ();

    picosoc_bus_decoder #(
        .NUM_SLAVES     (NS),
        .SLAVE_BASE     (BASE_P),
        .SLAVE_MASK     (MASK_P),
        .TIMEOUT_CYCLES (TMO),
        .ERR_RDATA      (ERR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .err_clear (err_clear),
        .err_flag  (err_flag),
        .err_addr  (err_addr),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [31:0] exp_q [$];
    logic        m_err_flag;
    logic [31:0] m_err_addr;
    logic        force_clear;
    int          n_checks;
    int          n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Lowest-index region whose masked address equals its base; -1 if none.
    function automatic int ref_target(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & mask_tab[i]) == base_tab[i]) return i;
        end
        return -1;
    endfunction

    // Random responses on every slave lane; the lane under test is held not-ready.
    task automatic drive_noise(input int quiet);
        bus.s_ready = NS'($urandom);
        for (int i = 0; i < NS; i++) bus.s_rdata[32*i +: 32] = $urandom;
        if (quiet >= 0) bus.s_ready[quiet] = 1'b0;
    endtask

    // One clock edge: update the error model, then check the per-cycle outputs.
    task automatic step(input logic err_ev, input logic [31:0] err_a,
                        input logic [NS-1:0] exp_sv, input logic exp_rdy);
        err_clear = force_clear ? 1'b1 : ($urandom_range(0, 5) == 0);
        @(posedge clk);
        if (reset) begin
            m_err_flag = 1'b0;
            m_err_addr = '0;
        end else if (err_ev) begin
            m_err_flag = 1'b1;
            m_err_addr = err_a;
        end else if (err_clear) begin
            m_err_flag = 1'b0;
        end
        #1;
        check("s_valid",   32'(bus.s_valid),   32'(exp_sv));
        check("mem_ready", 32'(bus.mem_ready), 32'(exp_rdy));
        check("err_flag",  32'(err_flag),      32'(m_err_flag));
        check("err_addr",  err_addr,           m_err_addr);
        @(negedge clk);
    endtask

    // Full CPU transaction. k = WAIT cycle in which the slave answers
    // (0 = first cycle s_valid is seen); k >= TMO means it never answers in time.
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb,
                           input logic [31:0] wdata, input int k, input logic [31:0] rd_val);
        int            sel;
        int            lat;
        logic          ok;
        logic [NS-1:0] sv;
        logic [NS-1:0] sv_e;
        sel = ref_target(addr);
        ok  = (sel >= 0) && (k < TMO);
        if (sel < 0)       lat = 0;
        else if (k < TMO)  lat = k + 1;
        else               lat = TMO;
        sv = '0;
        if (sel >= 0) sv[sel] = 1'b1;
        exp_q.push_back(ok ? rd_val : ERR);

        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wstrb = wstrb;
        bus.mem_wdata = wdata;
        for (int e = 0; e <= lat; e++) begin
            drive_noise(sel);
            if (sel >= 0 && e == k + 1) begin
                bus.s_ready[sel]           = 1'b1;
                bus.s_rdata[32*sel +: 32]  = rd_val;
            end
            sv_e = (e < lat) ? sv : '0;
            step((e == lat) && !ok, addr, sv_e, (e == lat));
            if (e == 0 && sel >= 0) begin
                check("s_addr",  bus.s_addr,         addr);
                check("s_wstrb", 32'(bus.s_wstrb),   32'(wstrb));
                check("s_wdata", bus.s_wdata,        wdata);
            end
            if (e == lat) check("mem_rdata", bus.mem_rdata, exp_q.pop_front());
        end

        // Response cycle: the request may still be held; it must be ignored.
        bus.mem_valid = 1'($urandom_range(0, 1));
        drive_noise(-1);
        step(1'b0, '0, '0, 1'b0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return {22'h0, 8'($urandom), 2'b00};
            1:       return 32'h0200_0000 | {22'h0, 8'($urandom), 2'b00};
            2:       return 32'h0200_0400 | 32'($urandom_range(0, 32'hBFF));
            3:       return 32'h0400_0000 | {8'h0, 24'($urandom)};
            4:       return 32'h1000_0000 | 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_bad       = 0;
        m_err_flag  = 1'b0;
        m_err_addr  = '0;
        force_clear = 1'b0;
        reset       = 1'b1;
        err_clear   = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wstrb = '0;
        bus.mem_wdata = '0;
        bus.s_ready   = '0;
        bus.s_rdata   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_valid",   32'(bus.s_valid),   32'h0);
        check("rst_mem_ready", 32'(bus.mem_ready), 32'h0);
        check("rst_mem_rdata", bus.mem_rdata,      32'h0);
        check("rst_s_addr",    bus.s_addr,         32'h0);
        check("rst_s_wstrb",   32'(bus.s_wstrb),   32'h0);
        check("rst_s_wdata",   bus.s_wdata,        32'h0);
        check("rst_err_flag",  32'(err_flag),      32'h0);
        check("rst_err_addr",  err_addr,           32'h0);
        check("rst_state",     32'(state_dbg),     32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Read with minimum latency, then an unmapped read back-to-back
        run_txn(32'h0000_0010, 4'b0000, 32'h0, 0, 32'h1234_5678);
        run_txn(32'h0300_0000, 4'b0000, 32'h0, 0, 32'h0);
        // Slave 1 never answers; then answers exactly in the last allowed cycle
        run_txn(32'h0200_0800, 4'b0000, 32'h0, 255, 32'h0);
        run_txn(32'h0200_0804, 4'b0000, 32'h0, TMO - 1, 32'h5A5A_0001);
        run_txn(32'h0200_0808, 4'b0000, 32'h0, TMO, 32'h0);
        // Overlap resolves to slave 0; clear coinciding with a new error keeps the flag
        run_txn(32'h0200_0004, 4'b0000, 32'h0, 1, 32'hC0DE_0004);
        force_clear = 1'b1;
        run_txn(32'h0300_0040, 4'b0000, 32'h0, 0, 32'h0);
        force_clear = 1'b0;
        // Write to slave 2
        run_txn(32'h0400_0100, 4'b0011, 32'hAABB_CCDD, 2, 32'h7777_0000);

        // CPU drops mem_valid while waiting: silent abort
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0200_0C00;
        drive_noise(1);
        step(1'b0, '0, 4'b0010, 1'b0);
        bus.mem_valid = 1'b0;
        drive_noise(1);
        step(1'b0, '0, 4'b0000, 1'b0);
        check("abort_state", 32'(state_dbg), 32'h0);

        // Reset in WAIT, then a normal read
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0200_0900;
        drive_noise(1);
        step(1'b0, '0, 4'b0010, 1'b0);
        reset = 1'b1;
        drive_noise(1);
        step(1'b0, '0, 4'b0000, 1'b0);
        check("rst_wait_state", 32'(state_dbg),  32'h0);
        check("rst_wait_rdata", bus.mem_rdata,   32'h0);
        reset = 1'b0;
        bus.mem_valid = 1'b0;
        run_txn(32'h0200_0900, 4'b0000, 32'h0, 3, 32'h0BAD_F00D);

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            run_txn(rand_addr(), 4'($urandom_range(0, 15)), $urandom,
                    int'($urandom_range(0, TMO + 2)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                bus.mem_valid = 1'b0;
                drive_noise(-1);
                step(1'b0, '0, '0, 1'b0);
            end
        end

        check("exp_q_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
